// File: rtl/vend_pkg.sv
// Shared encodings for the vending order controller: state codes, note codes and values,
// and the fixed 4x4 goods price table.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PAY    = 3'd2,
    ST_VEND   = 3'd3,
    ST_CHANGE = 3'd4
  } state_t;

  localparam logic [2:0] DEN_1  = 3'd0;
  localparam logic [2:0] DEN_5  = 3'd1;
  localparam logic [2:0] DEN_10 = 3'd2;
  localparam logic [2:0] DEN_20 = 3'd3;
  localparam logic [2:0] DEN_50 = 3'd4;

  typedef struct packed {
    logic       valid;
    logic [3:0] price;
  } price_t;

  // Row-major: index = (row-1)*4 + (col-1)
  localparam logic [3:0] PRICE_TABLE [16] = '{
    4'd3,  4'd4, 4'd6,  4'd3,
    4'd10, 4'd8, 4'd9,  4'd7,
    4'd4,  4'd6, 4'd15, 4'd8,
    4'd9,  4'd4, 4'd5,  4'd5
  };

  function automatic logic [5:0] denom_value(input logic [2:0] code);
    logic [5:0] v;
    case (code)
      DEN_1:   v = 6'd1;
      DEN_5:   v = 6'd5;
      DEN_10:  v = 6'd10;
      DEN_20:  v = 6'd20;
      DEN_50:  v = 6'd50;
      default: v = 6'd0;
    endcase
    return v;
  endfunction

  function automatic logic denom_valid(input logic [2:0] code);
    return (code <= DEN_50);
  endfunction

  function automatic price_t price_lookup(input logic [2:0] hi, input logic [2:0] lo);
    price_t     r;
    logic [1:0] row;
    logic [1:0] col;
    row     = hi[1:0] - 2'd1;
    col     = lo[1:0] - 2'd1;
    r.valid = (hi >= 3'd1) && (hi <= 3'd4) && (lo >= 3'd1) && (lo <= 3'd4);
    r.price = r.valid ? PRICE_TABLE[{row, col}] : 4'd0;
    return r;
  endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Pays out a loaded amount one note at a time, largest note first, over valid/ready.
module vend_change_dispenser import vend_pkg::*; #(
  parameter int MONEY_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [MONEY_W-1:0] amount,
  input  logic               change_ready,
  output logic               change_valid,
  output logic [2:0]         change_denom,
  output logic               done
);

  logic [MONEY_W-1:0] remaining;
  logic [MONEY_W-1:0] note;
  logic [MONEY_W-1:0] after_note;

  function automatic logic [2:0] pick_note(input logic [MONEY_W-1:0] amt);
    logic [2:0] code;
    if (amt >= MONEY_W'(50))      code = DEN_50;
    else if (amt >= MONEY_W'(20)) code = DEN_20;
    else if (amt >= MONEY_W'(10)) code = DEN_10;
    else if (amt >= MONEY_W'(5))  code = DEN_5;
    else                          code = DEN_1;
    return code;
  endfunction

  assign note       = MONEY_W'(denom_value(change_denom));
  assign after_note = remaining - note;
  assign done       = change_valid && change_ready && (after_note == '0);

  // Denomination is only recomputed on load or an accepted note, so it holds during stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining    <= '0;
      change_valid <= 1'b0;
      change_denom <= DEN_1;
    end else if (load) begin
      remaining    <= amount;
      change_valid <= (amount != '0);
      change_denom <= pick_note(amount);
    end else if (change_valid && change_ready) begin
      remaining    <= after_note;
      change_valid <= (after_note != '0);
      change_denom <= pick_note(after_note);
    end else begin
      remaining    <= remaining;
      change_valid <= change_valid;
      change_denom <= change_denom;
    end
  end

endmodule

// File: rtl/vend_order_ctrl.sv
// Vending order controller: builds a multi-line order, collects notes, hands off the vend
// and returns change or a refund through the change dispenser.
module vend_order_ctrl import vend_pkg::*; #(
  parameter int MAX_ITEMS   = 4,
  parameter int QTY_W       = 2,
  parameter int MONEY_W     = 10,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               add_item,
  input  logic               confirm,
  input  logic               cancel,
  input  logic [2:0]         type_hi,
  input  logic [2:0]         type_lo,
  input  logic [QTY_W-1:0]   qty,
  input  logic               coin_valid,
  input  logic [2:0]         coin_sel,
  input  logic               vend_ready,
  input  logic               change_ready,
  output logic [2:0]         state_out,
  output logic [MONEY_W-1:0] need_money,
  output logic [MONEY_W-1:0] input_money,
  output logic [3:0]         item_count,
  output logic               vend_valid,
  output logic               change_valid,
  output logic [2:0]         change_denom,
  output logic               coin_reject,
  output logic               sel_err
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int SUM_W = MONEY_W + 1;

  state_t             state, next_state;
  logic [MONEY_W-1:0] need_next, input_next, load_amount, item_price;
  logic [3:0]         count_next;
  logic [TMR_W-1:0]   timer, timer_next, timer_run;
  logic [SUM_W-1:0]   coin_sum;
  logic               sel_err_next, coin_reject_next, load, change_done;
  logic               any_pulse, timeout, add_ok, coin_ok;
  price_t             sel_price;

  assign sel_price  = price_lookup(type_hi, type_lo);
  assign item_price = MONEY_W'(sel_price.price) * MONEY_W'(qty);
  assign add_ok     = add_item && sel_price.valid && (qty != '0) && (item_count < 4'(MAX_ITEMS));
  // One extra bit catches a sum past the register range
  assign coin_sum   = SUM_W'(input_money) + SUM_W'(denom_value(coin_sel));
  assign coin_ok    = denom_valid(coin_sel) && !coin_sum[MONEY_W];
  assign any_pulse  = add_item || confirm || cancel || coin_valid;
  assign timer_run  = any_pulse ? '0 : timer + TMR_W'(1);
  assign timeout    = !any_pulse && (timer == TMR_W'(TIMEOUT_CYC - 1));
  assign state_out  = state;

  // Next-state, order/payment updates and pulse outputs
  always_comb begin
    next_state       = state;
    need_next        = need_money;
    input_next       = input_money;
    count_next       = item_count;
    timer_next       = '0;
    sel_err_next     = 1'b0;
    coin_reject_next = 1'b0;
    load             = 1'b0;
    load_amount      = '0;
    case (state)
      ST_IDLE: begin
        if (confirm) begin
          next_state = ST_SELECT;
          need_next  = '0;
          input_next = '0;
          count_next = 4'd0;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_SELECT: begin
        timer_next = timer_run;
        if (cancel || timeout) begin
          next_state = ST_IDLE;
          timer_next = '0;
        end else begin
          if (add_ok) begin
            need_next  = need_money + item_price;
            count_next = item_count + 4'd1;
          end else begin
            sel_err_next = add_item;
          end
          if (confirm) begin
            if ((item_count == 4'd0) && !add_ok) sel_err_next = 1'b1;
            else                                 next_state   = ST_PAY;
          end else begin
            next_state = ST_SELECT;
          end
        end
      end
      ST_PAY: begin
        timer_next = timer_run;
        if (cancel || timeout) begin
          load        = 1'b1;
          load_amount = input_money;
          next_state  = ST_CHANGE;
          timer_next  = '0;
        end else begin
          if (coin_valid) begin
            if (coin_ok) input_next       = coin_sum[MONEY_W-1:0];
            else         coin_reject_next = 1'b1;
          end else begin
            input_next = input_money;
          end
          // Registered input_money: a same-cycle coin does not count towards this confirm
          if (confirm && (input_money >= need_money)) next_state = ST_VEND;
          else                                        next_state = ST_PAY;
        end
      end
      ST_VEND: begin
        if (vend_ready) begin
          load        = 1'b1;
          load_amount = input_money - need_money;
          next_state  = (input_money == need_money) ? ST_IDLE : ST_CHANGE;
        end else begin
          next_state = ST_VEND;
        end
      end
      ST_CHANGE: begin
        if (change_done || !change_valid) next_state = ST_IDLE;
        else                              next_state = ST_CHANGE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Controller registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      need_money  <= '0;
      input_money <= '0;
      item_count  <= 4'd0;
      timer       <= '0;
      vend_valid  <= 1'b0;
      coin_reject <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      state       <= next_state;
      need_money  <= need_next;
      input_money <= input_next;
      item_count  <= count_next;
      timer       <= timer_next;
      vend_valid  <= (next_state == ST_VEND);
      coin_reject <= coin_reject_next;
      sel_err     <= sel_err_next;
    end
  end

  vend_change_dispenser #(.MONEY_W(MONEY_W)) u_change (
    .clk          (sys_clk),
    .rst          (sys_rst),
    .load         (load),
    .amount       (load_amount),
    .change_ready (change_ready),
    .change_valid (change_valid),
    .change_denom (change_denom),
    .done         (change_done)
  );

endmodule

// File: tb/tb_vend_order_ctrl.sv
// Bench for vend_order_ctrl: directed order/pay/refund scenarios plus randomized traffic,
// every cycle compared against a transaction-level model of the vending rules.
module tb_vend_order_ctrl;

  localparam int MAX_ITEMS = 4;
  localparam int QTY_W     = 2;
  localparam int MONEY_W   = 10;
  localparam int TO        = 40;
  localparam int MONEY_MAX = (1 << MONEY_W) - 1;
  localparam int S_IDLE = 0, S_SELECT = 1, S_PAY = 2, S_VEND = 3, S_CHANGE = 4;

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic               add_item = 1'b0, confirm = 1'b0, cancel = 1'b0, coin_valid = 1'b0;
  logic               vend_ready = 1'b0, change_ready = 1'b0;
  logic [2:0]         type_hi = 3'd0, type_lo = 3'd0, coin_sel = 3'd0;
  logic [QTY_W-1:0]   qty = '0;
  logic [2:0]         state_out, change_denom;
  logic [MONEY_W-1:0] need_money, input_money;
  logic [3:0]         item_count;
  logic               vend_valid, change_valid, coin_reject, sel_err;

  int total = 0;
  int bad   = 0;

  int price_tab [4][4] = '{'{3, 4, 6, 3}, '{10, 8, 9, 7}, '{4, 6, 15, 8}, '{9, 4, 5, 5}};
  int note_val  [5]    = '{1, 5, 10, 20, 50};

  int m_st, m_need, m_in, m_cnt, m_idle;
  bit m_sel_err, m_rej;
  int chg_q[$];

  vend_order_ctrl #(
    .MAX_ITEMS(MAX_ITEMS), .QTY_W(QTY_W), .MONEY_W(MONEY_W), .TIMEOUT_CYC(TO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .add_item(add_item), .confirm(confirm),
    .cancel(cancel), .type_hi(type_hi), .type_lo(type_lo), .qty(qty),
    .coin_valid(coin_valid), .coin_sel(coin_sel), .vend_ready(vend_ready),
    .change_ready(change_ready), .state_out(state_out), .need_money(need_money),
    .input_money(input_money), .item_count(item_count), .vend_valid(vend_valid),
    .change_valid(change_valid), .change_denom(change_denom),
    .coin_reject(coin_reject), .sel_err(sel_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_st = S_IDLE; m_need = 0; m_in = 0; m_cnt = 0; m_idle = 0;
    m_sel_err = 1'b0; m_rej = 1'b0;
    chg_q.delete();
  endfunction

  // Change as a list of notes, largest first
  function automatic void load_change(input int amt);
    int left;
    int k;
    left = amt;
    chg_q.delete();
    while (left > 0) begin
      k = 4;
      while (note_val[k] > left) k--;
      chg_q.push_back(k);
      left -= note_val[k];
    end
  endfunction

  function automatic void model_step();
    bit any, tmo, ok;
    int p, v, old_in, old_cnt;
    any = add_item || confirm || cancel || coin_valid;
    m_sel_err = 1'b0;
    m_rej     = 1'b0;
    case (m_st)
      S_IDLE: if (confirm) begin
        m_st = S_SELECT; m_need = 0; m_in = 0; m_cnt = 0; m_idle = 0;
      end
      S_SELECT, S_PAY: begin
        m_idle = any ? 0 : m_idle + 1;
        tmo    = (m_idle == TO);
        if (m_st == S_SELECT) begin
          if (cancel || tmo) m_st = S_IDLE;
          else begin
            p = (type_hi >= 1 && type_hi <= 4 && type_lo >= 1 && type_lo <= 4) ?
                price_tab[type_hi-1][type_lo-1] : 0;
            ok      = add_item && (p > 0) && (qty != 0) && (m_cnt < MAX_ITEMS);
            old_cnt = m_cnt;
            if (ok) begin m_need += p * int'(qty); m_cnt++; end
            else if (add_item) m_sel_err = 1'b1;
            if (confirm) begin
              if (old_cnt == 0 && !ok) m_sel_err = 1'b1;
              else begin m_st = S_PAY; m_idle = 0; end
            end
          end
        end else begin
          if (cancel || tmo) begin
            load_change(m_in);
            m_st = S_CHANGE;
          end else begin
            old_in = m_in;
            if (coin_valid) begin
              v = (coin_sel <= 4) ? note_val[coin_sel] : 0;
              if (v > 0 && m_in + v <= MONEY_MAX) m_in += v;
              else m_rej = 1'b1;
            end
            if (confirm && old_in >= m_need) m_st = S_VEND;
          end
        end
      end
      S_VEND: if (vend_ready) begin
        load_change(m_in - m_need);
        m_st = (m_in == m_need) ? S_IDLE : S_CHANGE;
      end
      S_CHANGE: begin
        if (chg_q.size() == 0) m_st = S_IDLE;
        else if (change_ready) begin
          void'(chg_q.pop_front());
          if (chg_q.size() == 0) m_st = S_IDLE;
        end
      end
      default: m_st = S_IDLE;
    endcase
  endfunction

  task automatic compare_all();
    bit cv;
    cv = (m_st == S_CHANGE) && (chg_q.size() > 0);
    chk("state", int'(state_out), m_st);
    chk("need_money", int'(need_money), m_need);
    chk("input_money", int'(input_money), m_in);
    chk("item_count", int'(item_count), m_cnt);
    chk("vend_valid", int'(vend_valid), int'(m_st == S_VEND));
    chk("change_valid", int'(change_valid), int'(cv));
    if (cv) chk("change_denom", int'(change_denom), chg_q[0]);
    chk("coin_reject", int'(coin_reject), int'(m_rej));
    chk("sel_err", int'(sel_err), int'(m_sel_err));
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic apply_reset();
    sys_rst = 1'b1;
    {add_item, confirm, cancel, coin_valid, vend_ready, change_ready} = 6'b0;
    model_reset();
    @(posedge sys_clk);
    #1;
    chk("rst_state", int'(state_out), S_IDLE);
    chk("rst_need", int'(need_money), 0);
    chk("rst_in", int'(input_money), 0);
    chk("rst_cnt", int'(item_count), 0);
    chk("rst_vend_valid", int'(vend_valid), 0);
    chk("rst_change_valid", int'(change_valid), 0);
    chk("rst_denom", int'(change_denom), 0);
    chk("rst_reject", int'(coin_reject), 0);
    chk("rst_sel_err", int'(sel_err), 0);
    sys_rst = 1'b0;
  endtask

  task automatic press_confirm();
    confirm = 1'b1; cycle(); confirm = 1'b0;
  endtask

  task automatic press_cancel();
    cancel = 1'b1; cycle(); cancel = 1'b0;
  endtask

  task automatic add(input int hi, input int lo, input int q);
    type_hi = 3'(hi); type_lo = 3'(lo); qty = QTY_W'(q);
    add_item = 1'b1; cycle(); add_item = 1'b0;
  endtask

  task automatic coin(input int sel);
    coin_sel = 3'(sel); coin_valid = 1'b1; cycle(); coin_valid = 1'b0;
  endtask

  initial begin
    int exp_codes [6];
    exp_codes = '{4, 3, 2, 1, 0, 0};
    apply_reset();

    // Order 0x21 x2, pay 25, vend, one 5 note of change
    press_confirm();
    add(2, 1, 2);
    chk("s1_need", int'(need_money), 20);
    press_confirm();
    coin(3);
    coin(1);
    chk("s1_in", int'(input_money), 25);
    press_confirm();
    chk("s1_vend_valid", int'(vend_valid), 1);
    cycle();
    vend_ready = 1'b1; cycle(); vend_ready = 1'b0;
    chk("s1_change_denom", int'(change_denom), 1);
    change_ready = 1'b1; cycle(); change_ready = 1'b0;
    chk("s1_back_idle", int'(state_out), S_IDLE);

    // Empty confirm, invalid code, zero qty, too many lines
    press_confirm();
    press_confirm();
    chk("s2_empty_confirm", int'(sel_err), 1);
    add(1, 1, 1); add(1, 2, 1); add(1, 3, 1);
    add(1, 5, 1);
    chk("s2_bad_code_err", int'(sel_err), 1);
    chk("s2_bad_code_need", int'(need_money), 13);
    add(2, 2, 0);
    chk("s2_zero_qty_err", int'(sel_err), 1);
    add(1, 4, 1);
    add(4, 4, 3);
    chk("s2_full_err", int'(sel_err), 1);
    chk("s2_full_cnt", int'(item_count), 4);
    press_cancel();

    // Refund of 87 with three-cycle stalls per note
    press_confirm();
    add(3, 3, 3);
    press_confirm();
    coin(4); coin(3); coin(2); coin(1); coin(0); coin(0);
    chk("s3_in", int'(input_money), 87);
    press_cancel();
    for (int n = 0; n < 6; n++) begin
      repeat (3) cycle();
      chk("s3_refund_note", int'(change_denom), exp_codes[n]);
      change_ready = 1'b1; cycle(); change_ready = 1'b0;
    end
    chk("s3_done", int'(state_out), S_IDLE);

    // Fill to 1000 and overflow with a 50
    press_confirm();
    add(1, 1, 1);
    press_confirm();
    repeat (20) coin(4);
    chk("s4_in_1000", int'(input_money), 1000);
    coin(4);
    chk("s4_reject", int'(coin_reject), 1);
    chk("s4_in_kept", int'(input_money), 1000);
    coin(6);
    chk("s4_bad_sel_reject", int'(coin_reject), 1);
    press_cancel();
    change_ready = 1'b1; repeat (22) cycle(); change_ready = 1'b0;
    chk("s4_refund_done", int'(state_out), S_IDLE);

    // Coin and confirm in the same cycle
    press_confirm();
    add(2, 1, 1);
    press_confirm();
    coin_sel = 3'd2; coin_valid = 1'b1; confirm = 1'b1;
    cycle();
    coin_valid = 1'b0; confirm = 1'b0;
    chk("s5_still_pay", int'(state_out), S_PAY);
    chk("s5_in", int'(input_money), 10);
    press_confirm();
    chk("s5_vend", int'(state_out), S_VEND);
    vend_ready = 1'b1; cycle(); vend_ready = 1'b0;
    chk("s5_idle_no_change", int'(state_out), S_IDLE);

    // Selection timeout
    press_confirm();
    repeat (TO) cycle();
    chk("s6_select_timeout", int'(state_out), S_IDLE);

    // Pay timeout refunds 7, reset mid-refund
    press_confirm();
    add(1, 1, 1);
    press_confirm();
    coin(1); coin(0); coin(0);
    repeat (TO - 1) cycle();
    chk("s7_before_timeout", int'(state_out), S_PAY);
    cycle();
    chk("s7_timeout_change", int'(state_out), S_CHANGE);
    chk("s7_first_note", int'(change_denom), 1);
    change_ready = 1'b1; cycle(); change_ready = 1'b0;
    chk("s7_second_note", int'(change_denom), 0);
    apply_reset();

    // Randomized traffic, alternating busy and quiet stretches
    for (int i = 0; i < 4000; i++) begin
      int r;
      bit quiet;
      quiet        = ((i / 400) % 2) == 1;
      r            = quiet ? 80 : 6;
      add_item     = ($urandom % r) == 0;
      confirm      = ($urandom % (r + 2)) == 0;
      cancel       = ($urandom % (r * 8)) == 0;
      coin_valid   = ($urandom % (quiet ? r : 3)) == 0;
      type_hi      = 3'($urandom_range(0, 5));
      type_lo      = 3'($urandom_range(0, 5));
      qty          = QTY_W'($urandom);
      coin_sel     = 3'($urandom_range(0, 6));
      vend_ready   = ($urandom % 3) == 0;
      change_ready = ($urandom % 2) == 0;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
